nios_sprite_pio: RTL and testbench
==================================

// Module: nios_sprite_pio
// PURPOSE
//  Parametrised, double-buffered Avalon-MM output PIO for sprite coordinates
//  (doodle/platform x/y). Nios writes shadow registers at any time. Active
//  outputs update atomically on the frame-sync rising edge, so the VGA
//  renderer never sees a half-updated position set.
//  Sits between the Nios Avalon-MM fabric and the sprite/VGA drawing logic.
// PARAMETERS
//  NCH     4   number of output channels; 1..12
//  WIDTH   10  bits per channel; 1..32
//  ADDR_W  4   Avalon word-address width
// PORTS
//  clk         in   1           system clock
//  reset_n     in   1           asynchronous, active-low reset
//  address     in   ADDR_W      Avalon word address
//  chipselect  in   1           Avalon select
//  write_n     in   1           Avalon write strobe, active low
//  writedata   in   32          Avalon write data
//  readdata    out  32          Avalon read data; zero latency, zero-extended
//  frame_sync  in   1           vsync from the VGA controller; asynchronous to clk
//  out_port    out  NCH*WIDTH   active values; channel i at [i*WIDTH +: WIDTH]
//  irq         out  1           commit interrupt = irq_flag & CTRL.irq_en
// BEHAVIOUR
//  Register map (word addresses):
//   0 CTRL     [0] imm_mode, [1] irq_en
//   1 STATUS   [0] pending (RO), [1] irq_flag (write 1 to clear)
//   2 FRAMECNT [15:0] free-running sync-edge count (RO)
//   3 COMMIT   write with [0]=1 forces a commit (sw_commit)
//   4+i        channel i shadow, i<NCH; reads return the shadow value
//  - A write is chipselect & ~write_n. Writes to unmapped or RO fields are ignored.
//  - Reads of unmapped addresses and unused bits return 0.
//  - Reset: shadow, active, CTRL, pending, irq_flag, FRAMECNT and sync FFs = 0.
//    out_port=0, irq=0.
//  - frame_sync passes through a 2-FF synchroniser plus an edge register.
//    sync_rise = s2 & ~s3. sync_rise lags the pin by 2-3 clk.
//    If frame_sync is high at reset release, one sync_rise occurs (counted).
//  - Each sync_rise: FRAMECNT += 1, wraps 0xFFFF -> 0.
//  - commit_evt = (sync_rise | sw_commit) & pending.
//    On commit_evt: active <= shadow (all channels, same cycle), pending <= 0,
//    irq_flag <= 1. The result is visible on out_port the next cycle.
//  - Shadow write with imm_mode=0: shadow updates and pending <= 1.
//  - Shadow write with imm_mode=1: shadow and active both update. pending unchanged.
//  - Simultaneous shadow write and commit_evt:
//    the commit copies the pre-write shadow values;
//    the written channel's new shadow value is held, and pending stays 1 (write wins);
//    in imm_mode the written channel's active takes writedata (write wins over commit).
//  - sw_commit with pending=0 has no effect.
//  - STATUS W1C on irq_flag in the same cycle as commit_evt: irq_flag stays 1 (set wins).
//  - Switching imm_mode 1->0 leaves pending as is. No implicit commit.
//  - Reset asserted mid-frame: everything returns to reset values immediately (async).
//    There is no partial commit.
// STRUCTURE
//  - Shared package nios_pio_pkg: register offsets (CTRL/STATUS/FRAMECNT/
//    COMMIT/CH_BASE=4) and CTRL/STATUS bit positions.
//  - Sub-module pio_sync_edge: 2-FF synchroniser + rising-edge detect, async reset.
//  - Top level: Avalon decode, shadow/active arrays (generate loop), status, counter.
// TESTING
//  1 Reset, then read all addresses -> all readdata 0, out_port=0, irq=0.
//  2 Write ch0=0x155 (imm=0) -> out_port ch0 stays 0, STATUS=0x1.
//    Pulse frame_sync -> ch0=0x155 within 4 clk, STATUS=0x2.
//  3 irq_en=1, commit -> irq=1. Write STATUS=0x2 -> irq=0.
//    W1C coincident with commit -> irq stays 1.
//  4 imm_mode=1, write ch1=0x3FF -> out_port ch1=0x3FF next clk, pending=0.
//  5 Shadow write ch2=0x0AA in the same cycle as sync_rise, shadow was 0x011
//    -> active=0x011 and pending=1. Next frame_sync -> active=0x0AA.
//  6 0x10000 frame_sync pulses -> FRAMECNT wraps to 0.
//    COMMIT write with pending=0 -> out_port unchanged, irq_flag 0.

Source files
------------

// File: rtl/nios_pio_pkg.sv
// Shared register map and bit positions for the double-buffered sprite PIO.
package nios_pio_pkg;

    localparam int unsigned REG_CTRL     = 32'd0;
    localparam int unsigned REG_STATUS   = 32'd1;
    localparam int unsigned REG_FRAMECNT = 32'd2;
    localparam int unsigned REG_COMMIT   = 32'd3;
    localparam int unsigned CH_BASE      = 32'd4;

    localparam int unsigned CTRL_IMM_BIT     = 32'd0;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 32'd1;
    localparam int unsigned STAT_PENDING_BIT = 32'd0;
    localparam int unsigned STAT_IRQ_BIT     = 32'd1;
    localparam int unsigned COMMIT_BIT       = 32'd0;

    localparam int unsigned FRAMECNT_W = 32'd16;

    function automatic logic is_word(input logic [31:0] addr, input int unsigned offset);
        return (addr == offset);
    endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Two-flop synchroniser for an asynchronous level plus a registered rising-edge detect.
module pio_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic sync1_r;
    logic sync2_r;
    logic sync3_r;

    // Synchroniser chain; sync3_r remembers the previous synchronised level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= d;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign rise = sync2_r & ~sync3_r;

endmodule

// File: rtl/nios_sprite_pio.sv
// Double-buffered Avalon-MM output PIO: software fills shadow registers, and the
// active set seen by the renderer is swapped atomically on frame sync or on request.
module nios_sprite_pio #(
    parameter int NCH    = 4,
    parameter int WIDTH  = 10,
    parameter int ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    input  logic                    frame_sync,
    output logic [NCH*WIDTH-1:0]    out_port,
    output logic                    irq
);

    import nios_pio_pkg::*;

    logic                   wr_s;
    logic                   ctrl_wr_s;
    logic                   status_wr_s;
    logic                   sw_commit_s;
    logic                   commit_evt_s;
    logic                   sync_rise_s;
    logic [NCH-1:0]         ch_wr_s;
    logic [NCH*WIDTH-1:0]   shadow_vec_s;
    logic [31:0]            ch_rd_s;
    logic [31:0]            addr_s;

    logic                   imm_mode_r;
    logic                   irq_en_r;
    logic                   pending_r;
    logic                   irq_flag_r;
    logic [FRAMECNT_W-1:0]  frame_cnt_r;

    logic                   unused_wdata;

    pio_sync_edge u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (frame_sync),
        .rise    (sync_rise_s)
    );

    assign addr_s       = 32'(address);
    assign wr_s         = chipselect & ~write_n;
    assign ctrl_wr_s    = wr_s & is_word(addr_s, REG_CTRL);
    assign status_wr_s  = wr_s & is_word(addr_s, REG_STATUS);
    assign sw_commit_s  = wr_s & is_word(addr_s, REG_COMMIT) & writedata[COMMIT_BIT];
    assign commit_evt_s = (sync_rise_s | sw_commit_s) & pending_r;
    assign unused_wdata = &{1'b0, writedata};

    // Control, status and frame counter; a shadow write re-arms pending even during a commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imm_mode_r  <= 1'b0;
            irq_en_r    <= 1'b0;
            pending_r   <= 1'b0;
            irq_flag_r  <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            if (ctrl_wr_s) begin
                imm_mode_r <= writedata[CTRL_IMM_BIT];
                irq_en_r   <= writedata[CTRL_IRQ_EN_BIT];
            end
            if ((|ch_wr_s) && !imm_mode_r) begin
                pending_r <= 1'b1;
            end else if (commit_evt_s) begin
                pending_r <= 1'b0;
            end
            if (commit_evt_s) begin
                irq_flag_r <= 1'b1;
            end else if (status_wr_s && writedata[STAT_IRQ_BIT]) begin
                irq_flag_r <= 1'b0;
            end
            if (sync_rise_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] shadow_r;
        logic [WIDTH-1:0] active_r;

        assign ch_wr_s[i] = wr_s & is_word(addr_s, CH_BASE + i);

        // Commit copies the pre-write shadow; an immediate-mode write overrides it.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                shadow_r <= '0;
                active_r <= '0;
            end else begin
                if (ch_wr_s[i]) begin
                    shadow_r <= writedata[WIDTH-1:0];
                end
                if (ch_wr_s[i] && imm_mode_r) begin
                    active_r <= writedata[WIDTH-1:0];
                end else if (commit_evt_s) begin
                    active_r <= shadow_r;
                end
            end
        end

        assign shadow_vec_s[i*WIDTH +: WIDTH] = shadow_r;
        assign out_port[i*WIDTH +: WIDTH]     = active_r;
    end

    // Channel readback mux, zero-extended to the bus width.
    always_comb begin
        ch_rd_s = 32'd0;
        for (int i = 0; i < NCH; i++) begin
            ch_rd_s = ch_rd_s | (is_word(addr_s, CH_BASE + i) ?
                                 32'(shadow_vec_s[i*WIDTH +: WIDTH]) : 32'd0);
        end
    end

    // Zero-latency register readback.
    always_comb begin
        readdata = 32'd0;
        if (is_word(addr_s, REG_CTRL)) begin
            readdata[CTRL_IMM_BIT]    = imm_mode_r;
            readdata[CTRL_IRQ_EN_BIT] = irq_en_r;
        end else if (is_word(addr_s, REG_STATUS)) begin
            readdata[STAT_PENDING_BIT] = pending_r;
            readdata[STAT_IRQ_BIT]     = irq_flag_r;
        end else if (is_word(addr_s, REG_FRAMECNT)) begin
            readdata[FRAMECNT_W-1:0] = frame_cnt_r;
        end else begin
            readdata = ch_rd_s;
        end
    end

    assign irq = irq_flag_r & irq_en_r;

endmodule

// File: tb/tb_nios_sprite_pio.sv
// Directed self-checking bench for nios_sprite_pio (NCH=4, WIDTH=10, ADDR_W=4).
module tb_nios_sprite_pio;

    localparam int NCH    = 4;
    localparam int WIDTH  = 10;
    localparam int ADDR_W = 4;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [ADDR_W-1:0]     address;
    logic                  chipselect;
    logic                  write_n;
    logic [31:0]           writedata;
    logic [31:0]           readdata;
    logic                  frame_sync;
    logic [NCH*WIDTH-1:0]  out_port;
    logic                  irq;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_ch [NCH];
    logic [15:0]      exp_fc;
    logic [31:0]      rd;

    nios_sprite_pio #(.NCH(NCH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .frame_sync (frame_sync),
        .out_port   (out_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [NCH*WIDTH-1:0] exp_out();
        logic [NCH*WIDTH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*WIDTH +: WIDTH] = exp_ch[i];
        return v;
    endfunction

    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic sync_pulse();
        @(negedge clk);
        frame_sync = 1'b1;
        repeat (3) @(negedge clk);
        frame_sync = 1'b0;
        repeat (3) @(negedge clk);
        exp_fc = exp_fc + 16'd1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; frame_sync = 1'b0; address = '0;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        exp_fc = 16'd0;
        for (int i = 0; i < NCH; i++) exp_ch[i] = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            bus_read(ADDR_W'(a), rd);
            checks++;
            if (rd !== 32'd0) begin
                errors++;
                $display("FAIL reset_read addr=%0d got=0x%08h exp=0x00000000", a, rd);
            end
        end
        checks++;
        if (out_port !== '0) begin
            errors++; $display("FAIL reset_out got=0x%h exp=0", out_port);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_commit_on_sync();
        bit found;
        bus_write(4'd4, 32'h155);
        checks++;
        if (out_port !== exp_out()) begin
            errors++; $display("FAIL shadow_only_out got=0x%h exp=0x%h", out_port, exp_out());
        end
        bus_read(4'd1, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++; $display("FAIL status_pending got=0x%h exp=0x1", rd);
        end
        exp_ch[0] = 10'h155;
        @(negedge clk);
        frame_sync = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_port === exp_out()) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL sync_commit_latency got=0x%h exp=0x%h", out_port, exp_out());
        end
        frame_sync = 1'b0;
        repeat (3) @(negedge clk);
        exp_fc = exp_fc + 16'd1;
        bus_read(4'd1, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++; $display("FAIL status_after_commit got=0x%h exp=0x2", rd);
        end
    endtask

    task automatic test_irq();
        bus_write(4'd1, 32'h2);
        bus_write(4'd0, 32'h2);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_cleared got=%b exp=0", irq);
        end
        bus_write(4'd7, 32'h123);
        bus_write(4'd3, 32'h1);
        exp_ch[3] = 10'h123;
        checks++;
        if (irq !== 1'b1 || out_port !== exp_out()) begin
            errors++; $display("FAIL sw_commit got irq=%b out=0x%h exp irq=1 out=0x%h", irq, out_port, exp_out());
        end
        bus_write(4'd1, 32'h2);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_w1c got=%b exp=0", irq);
        end
        // W1C lands in the same cycle as the sync-triggered commit
        bus_write(4'd7, 32'h0F0);
        @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        address = 4'd1; writedata = 32'h2; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        exp_ch[3] = 10'h0F0;
        checks++;
        if (irq !== 1'b1 || out_port !== exp_out()) begin
            errors++; $display("FAIL w1c_vs_commit got irq=%b out=0x%h exp irq=1 out=0x%h", irq, out_port, exp_out());
        end
        frame_sync = 1'b0;
        repeat (3) @(negedge clk);
        exp_fc = exp_fc + 16'd1;
    endtask

    task automatic test_imm_mode();
        bus_write(4'd0, 32'h3);
        bus_write(4'd1, 32'h2);
        bus_write(4'd5, 32'h3FF);
        exp_ch[1] = 10'h3FF;
        checks++;
        if (out_port !== exp_out()) begin
            errors++; $display("FAIL imm_out got=0x%h exp=0x%h", out_port, exp_out());
        end
        bus_read(4'd1, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL imm_pending got=0x%h exp=0x0", rd);
        end
        bus_read(4'd5, rd);
        checks++;
        if (rd !== 32'h3FF) begin
            errors++; $display("FAIL imm_shadow_read got=0x%h exp=0x3FF", rd);
        end
    endtask

    task automatic test_write_during_sync();
        bus_write(4'd0, 32'h0);
        bus_write(4'd6, 32'h011);
        @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        address = 4'd6; writedata = 32'h0AA; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        exp_ch[2] = 10'h011;
        checks++;
        if (out_port !== exp_out()) begin
            errors++; $display("FAIL coincident_active got=0x%h exp=0x%h", out_port, exp_out());
        end
        bus_read(4'd1, rd);
        checks++;
        if (rd !== 32'h3) begin
            errors++; $display("FAIL coincident_status got=0x%h exp=0x3", rd);
        end
        bus_read(4'd6, rd);
        checks++;
        if (rd !== 32'h0AA) begin
            errors++; $display("FAIL coincident_shadow got=0x%h exp=0x0AA", rd);
        end
        frame_sync = 1'b0;
        repeat (3) @(negedge clk);
        exp_fc = exp_fc + 16'd1;
        sync_pulse();
        exp_ch[2] = 10'h0AA;
        checks++;
        if (out_port !== exp_out()) begin
            errors++; $display("FAIL next_frame_active got=0x%h exp=0x%h", out_port, exp_out());
        end
    endtask

    task automatic test_framecnt();
        bus_read(4'd2, rd);
        checks++;
        if (rd !== 32'(exp_fc)) begin
            errors++; $display("FAIL framecnt got=0x%h exp=0x%h", rd, exp_fc);
        end
        repeat (3) sync_pulse();
        bus_read(4'd2, rd);
        checks++;
        if (rd !== 32'(exp_fc)) begin
            errors++; $display("FAIL framecnt_count got=0x%h exp=0x%h", rd, exp_fc);
        end
        // Preload near the top to reach the wrap without 64k pulses
        @(negedge clk);
        force dut.frame_cnt_r = 16'hFFFE;
        @(negedge clk);
        release dut.frame_cnt_r;
        exp_fc = 16'hFFFE;
        bus_read(4'd2, rd);
        checks++;
        if (rd !== 32'h0000FFFE) begin
            errors++; $display("FAIL framecnt_preload got=0x%h exp=0xFFFE", rd);
        end
        repeat (2) sync_pulse();
        bus_read(4'd2, rd);
        checks++;
        if (rd !== 32'(exp_fc) || exp_fc !== 16'h0000) begin
            errors++; $display("FAIL framecnt_wrap got=0x%h exp=0x0", rd);
        end
        checks++;
        if (out_port !== exp_out()) begin
            errors++; $display("FAIL idle_sync_out got=0x%h exp=0x%h", out_port, exp_out());
        end
    endtask

    task automatic test_commit_no_pending();
        bus_write(4'd1, 32'h2);
        bus_write(4'd3, 32'h1);
        checks++;
        if (out_port !== exp_out()) begin
            errors++; $display("FAIL nop_commit_out got=0x%h exp=0x%h", out_port, exp_out());
        end
        bus_read(4'd1, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL nop_commit_status got=0x%h exp=0x0", rd);
        end
    endtask

    task automatic test_async_reset();
        bus_write(4'd0, 32'h2);
        bus_write(4'd4, 32'h2AA);
        bus_write(4'd3, 32'h1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_port !== '0 || irq !== 1'b0) begin
            errors++; $display("FAIL async_reset got out=0x%h irq=%b exp 0/0", out_port, irq);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(4'd4, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_shadow got=0x%h exp=0x0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_commit_on_sync();
        test_irq();
        test_imm_mode();
        test_write_during_sync();
        test_framecnt();
        test_commit_no_pending();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
